// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM SDP read streamer.
package bram_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

  localparam int FIFO_DEPTH   = 2;
  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/bram_sdp_read_streamer_skid_fifo2.sv
// Two-entry first-word-fall-through FIFO; push and pop may coincide at any occupancy.
module skid_fifo2
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // When full, the write lands in the slot being popped this same cycle.
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/bram_sdp_read_streamer.sv
// Burst read sequencer for the BRAM SDP read port: issues REN/RD_ADDR and streams RDATA out.
module bram_sdp_read_streamer
  import bram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clock0,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ren_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] raddr_hold_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  len_m1;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  accepted_q;
  logic                  inflight_q;
  logic                  ren;
  logic                  pop;
  logic                  fifo_valid;
  logic [1:0]            fifo_count;
  logic [2:0]            credit_used;

  assign len_m1    = len_q - LEN_WIDTH'(1);
  assign next_addr = base_q + issued_q[ADDR_WIDTH-1:0];
  assign pop       = fifo_valid & m_ready_i;
  // A word leaving this cycle frees its slot in time for the read issued now.
  assign credit_used = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, inflight_q};

  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = (len_i == '0) ? FIN : RUN;
      end
      RUN: begin
        if ((issued_q < len_q) && (credit_used < 3'(FIFO_DEPTH))) begin
          ren = 1'b1;
          if (issued_q == len_m1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (accepted_q == len_m1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      accepted_q   <= '0;
      inflight_q   <= 1'b0;
      raddr_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= ren;
      if (ren) raddr_hold_q <= next_addr;
      if ((state_q == IDLE) && start_i) begin
        base_q     <= base_addr_i;
        len_q      <= len_i;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (ren) issued_q <= issued_q + LEN_WIDTH'(1);
        if (pop) accepted_q <= accepted_q + LEN_WIDTH'(1);
      end
    end
  end

  skid_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i       (clock0),
    .rst_i       (reset),
    .push_i      (inflight_q),
    .push_data_i (rdata_i),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .data_o      (m_data_o),
    .valid_o     (fifo_valid)
  );

  assign ren_o     = ren;
  assign raddr_o   = ren ? next_addr : raddr_hold_q;
  assign m_valid_o = fifo_valid;
  assign m_last_o  = fifo_valid & (accepted_q == len_m1);
  assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
  assign done_o    = (state_q == FIN);

endmodule

// File: tb/tb_bram_sdp_read_streamer.sv
// Directed bench for bram_sdp_read_streamer with a 1-cycle-latency BRAM model.
module tb_bram_sdp_read_streamer;

  logic        clock0;
  logic        reset;
  logic        start_i;
  logic [9:0]  base_addr_i;
  logic [10:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        ren_o;
  logic [9:0]  raddr_o;
  logic [35:0] rdata_i;
  logic        m_valid_o;
  logic [35:0] m_data_o;
  logic        m_last_o;
  logic        m_ready_i;

  int errors = 0;
  int checks = 0;

  logic [9:0]  ren_addr_q[$];
  int          ren_cyc_q[$];
  logic [35:0] beat_data_q[$];
  logic        beat_last_q[$];
  int          beat_cyc_q[$];
  int          done_cyc_q[$];
  int          stable_viol;
  int          ovf_viol;
  int          valid_viol;
  logic        busy_c1;

  bram_sdp_read_streamer dut (
    .clock0      (clock0),
    .reset       (reset),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ren_o       (ren_o),
    .raddr_o     (raddr_o),
    .rdata_i     (rdata_i),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready_i)
  );

  initial clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  function automatic logic [35:0] mw(input int a);
    logic [17:0] v;
    v = 18'(a);
    return {v, v};
  endfunction

  always @(posedge clock0) if (ren_o) rdata_i <= mw(int'(raddr_o));

  function automatic logic ready_of(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return ((c % 4) == 0) || ((c % 4) == 3);
  endfunction

  // Starts a burst and records every observable event until done_o or the cycle budget.
  task automatic run_burst(input logic [9:0] base, input logic [10:0] len, input int mode,
                           input int pulse_at, input int max_cyc);
    logic        prev_valid, prev_ready, pop, infl;
    logic [35:0] prev_data;
    int          occ;
    ren_addr_q.delete(); ren_cyc_q.delete(); beat_data_q.delete();
    beat_last_q.delete(); beat_cyc_q.delete(); done_cyc_q.delete();
    stable_viol = 0; ovf_viol = 0; valid_viol = 0; busy_c1 = 1'b0;
    @(negedge clock0);
    start_i = 1'b1; base_addr_i = base; len_i = len; m_ready_i = ready_of(mode, 0);
    #1;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0; occ = 0; infl = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clock0);
      start_i = (c == pulse_at);
      if (c == pulse_at) begin base_addr_i = 10'h155; len_i = 11'd3; end
      m_ready_i = ready_of(mode, c);
      #1;
      if (c == 1) busy_c1 = busy_o;
      if (prev_valid && !prev_ready && (!m_valid_o || m_data_o !== prev_data)) stable_viol++;
      if (m_valid_o !== (occ > 0)) valid_viol++;
      pop = m_valid_o & m_ready_i;
      if (ren_o && (occ - int'(pop) + int'(infl)) >= 2) ovf_viol++;
      if (ren_o) begin ren_addr_q.push_back(raddr_o); ren_cyc_q.push_back(c); end
      if (pop) begin
        beat_data_q.push_back(m_data_o); beat_last_q.push_back(m_last_o); beat_cyc_q.push_back(c);
      end
      occ = occ + int'(infl) - int'(pop);
      infl = ren_o;
      prev_valid = m_valid_o; prev_data = m_data_o; prev_ready = m_ready_i;
      if (done_o) begin done_cyc_q.push_back(c); break; end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b0;
    repeat (2) @(posedge clock0);
    @(negedge clock0);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done_o); end
    checks++; if (ren_o !== 1'b0) begin errors++; $display("FAIL rst_ren got %b want 0", ren_o); end
    checks++; if (raddr_o !== 10'h0) begin errors++; $display("FAIL rst_raddr got %h want 0", raddr_o); end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", m_valid_o); end
    checks++; if (m_data_o !== 36'h0) begin errors++; $display("FAIL rst_data got %h want 0", m_data_o); end
    checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", m_last_o); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    run_burst(10'h010, 11'd4, 0, 0, 30);
    checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy_c1); end
    checks++; if (ren_cyc_q.size() != 4) begin errors++; $display("FAIL basic_ren_count got %0d want 4", ren_cyc_q.size()); end
    for (int i = 0; i < ren_cyc_q.size() && i < 4; i++) begin
      checks++;
      if (ren_cyc_q[i] != i + 1 || ren_addr_q[i] !== 10'(16 + i)) begin
        errors++; $display("FAIL basic_ren%0d got cyc %0d addr %h want cyc %0d addr %h", i, ren_cyc_q[i], ren_addr_q[i], i + 1, 10'(16 + i));
      end
    end
    checks++; if (beat_data_q.size() != 4) begin errors++; $display("FAIL basic_beats got %0d want 4", beat_data_q.size()); end
    for (int i = 0; i < beat_data_q.size() && i < 4; i++) begin
      checks++;
      if (beat_data_q[i] !== mw(16 + i) || beat_last_q[i] !== (i == 3) || beat_cyc_q[i] != 3 + i) begin
        errors++; $display("FAIL basic_beat%0d got %h last %b cyc %0d want %h last %b cyc %0d", i, beat_data_q[i], beat_last_q[i], beat_cyc_q[i], mw(16 + i), (i == 3), 3 + i);
      end
    end
    checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != 7) begin errors++; $display("FAIL basic_done got %0d pulses at %0d want 1 at 7", done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1); end
  endtask

  task automatic test_back_pressure;
    run_burst(10'h000, 11'd8, 1, 0, 80);
    checks++; if (beat_data_q.size() != 8) begin errors++; $display("FAIL bp_beats got %0d want 8", beat_data_q.size()); end
    for (int i = 0; i < beat_data_q.size() && i < 8; i++) begin
      checks++;
      if (beat_data_q[i] !== mw(i) || beat_last_q[i] !== (i == 7)) begin
        errors++; $display("FAIL bp_beat%0d got %h last %b want %h last %b", i, beat_data_q[i], beat_last_q[i], mw(i), (i == 7));
      end
    end
    checks++; if (stable_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stable_viol); end
    checks++; if (ovf_viol != 0) begin errors++; $display("FAIL bp_ren_when_full got %0d want 0", ovf_viol); end
    checks++; if (valid_viol != 0) begin errors++; $display("FAIL bp_valid_vs_occupancy got %0d want 0", valid_viol); end
    checks++; if (ren_cyc_q.size() != 8 || ren_cyc_q[7] <= 8) begin errors++; $display("FAIL bp_ren_stall got %0d reads, last at %0d, want 8 reads ending after cycle 8", ren_cyc_q.size(), (ren_cyc_q.size() > 7) ? ren_cyc_q[7] : -1); end
    checks++; if (done_cyc_q.size() != 1 || beat_cyc_q.size() != 8 || done_cyc_q[0] != beat_cyc_q[7] + 1) begin errors++; $display("FAIL bp_done got %0d pulses want 1 right after last beat", done_cyc_q.size()); end
  endtask

  task automatic test_wrap;
    logic [9:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    run_burst(10'h3FE, 11'd4, 0, 0, 30);
    checks++; if (ren_addr_q.size() != 4) begin errors++; $display("FAIL wrap_ren_count got %0d want 4", ren_addr_q.size()); end
    for (int i = 0; i < ren_addr_q.size() && i < 4; i++) begin
      checks++; if (ren_addr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, ren_addr_q[i], exp_a[i]); end
    end
    for (int i = 0; i < beat_data_q.size() && i < 4; i++) begin
      checks++; if (beat_data_q[i] !== mw(int'(exp_a[i]))) begin errors++; $display("FAIL wrap_data%0d got %h want %h", i, beat_data_q[i], mw(int'(exp_a[i]))); end
    end
    checks++; if (beat_data_q.size() != 4 || done_cyc_q.size() != 1) begin errors++; $display("FAIL wrap_complete got %0d beats %0d done want 4 1", beat_data_q.size(), done_cyc_q.size()); end
  endtask

  task automatic test_zero_len;
    run_burst(10'h055, 11'd0, 0, 0, 6);
    checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != 1) begin errors++; $display("FAIL zero_done got %0d pulses at %0d want 1 at 1", done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1); end
    checks++; if (ren_cyc_q.size() != 0) begin errors++; $display("FAIL zero_ren got %0d want 0", ren_cyc_q.size()); end
    checks++; if (beat_data_q.size() != 0 || valid_viol != 0) begin errors++; $display("FAIL zero_valid got %0d beats want 0", beat_data_q.size()); end
  endtask

  task automatic test_ignored_start;
    run_burst(10'h020, 11'd6, 0, 2, 40);
    checks++; if (ren_addr_q.size() != 6) begin errors++; $display("FAIL ign_ren_count got %0d want 6", ren_addr_q.size()); end
    checks++; if (beat_data_q.size() != 6) begin errors++; $display("FAIL ign_beats got %0d want 6", beat_data_q.size()); end
    for (int i = 0; i < beat_data_q.size() && i < 6; i++) begin
      checks++;
      if (beat_data_q[i] !== mw(32 + i) || beat_last_q[i] !== (i == 5)) begin
        errors++; $display("FAIL ign_beat%0d got %h last %b want %h last %b", i, beat_data_q[i], beat_last_q[i], mw(32 + i), (i == 5));
      end
    end
    checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != 9) begin errors++; $display("FAIL ign_done got %0d pulses want 1 at 9", done_cyc_q.size()); end
  endtask

  task automatic test_reset_mid;
    int nb, nd;
    nb = 0; nd = 0;
    @(negedge clock0);
    start_i = 1'b1; base_addr_i = 10'h000; len_i = 11'd16; m_ready_i = 1'b1;
    #1;
    for (int c = 1; c <= 40 && nb < 3; c++) begin
      @(negedge clock0);
      start_i = 1'b0;
      #1;
      if (done_o) nd++;
      if (m_valid_o && m_ready_i) nb++;
    end
    checks++; if (nb != 3) begin errors++; $display("FAIL rmid_reach3 got %0d beats want 3", nb); end
    @(posedge clock0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, ren_o, m_valid_o, m_last_o, raddr_o, m_data_o} !== '0) begin
      errors++; $display("FAIL rmid_outputs got busy %b done %b ren %b valid %b last %b addr %h data %h want all 0", busy_o, done_o, ren_o, m_valid_o, m_last_o, raddr_o, m_data_o);
    end
    @(negedge clock0);
    if (done_o) nd++;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin @(negedge clock0); #1; if (done_o) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", nd); end
    run_burst(10'h100, 11'd2, 0, 0, 20);
    checks++;
    if (beat_data_q.size() != 2 || beat_data_q[0] !== mw(256) || beat_data_q[1] !== mw(257) || beat_last_q[1] !== 1'b1 || beat_last_q[0] !== 1'b0) begin
      errors++; $display("FAIL rmid_next_burst got %0d beats want 2 with data %h %h", beat_data_q.size(), mw(256), mw(257));
    end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL rmid_next_done got %0d want 1", done_cyc_q.size()); end
  endtask

  task automatic test_full_depth;
    int derr, nlast;
    derr = 0; nlast = 0;
    run_burst(10'h000, 11'd1024, 0, 0, 1100);
    checks++; if (beat_data_q.size() != 1024) begin errors++; $display("FAIL full_beats got %0d want 1024", beat_data_q.size()); end
    for (int i = 0; i < beat_data_q.size(); i++) begin
      if (beat_data_q[i] !== mw(i)) derr++;
      if (beat_last_q[i]) nlast++;
    end
    checks++; if (derr != 0) begin errors++; $display("FAIL full_data got %0d wrong words want 0", derr); end
    checks++; if (nlast != 1 || beat_last_q.size() != 1024 || beat_last_q[1023] !== 1'b1) begin errors++; $display("FAIL full_last got %0d last flags want 1 on beat 1023", nlast); end
    checks++;
    if (beat_cyc_q.size() != 1024 || beat_cyc_q[0] != 3 || beat_cyc_q[1023] != 1026) begin
      errors++; $display("FAIL full_throughput got first %0d last %0d want 3 1026", (beat_cyc_q.size() > 0) ? beat_cyc_q[0] : -1, (beat_cyc_q.size() == 1024) ? beat_cyc_q[1023] : -1);
    end
    checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != 1027) begin errors++; $display("FAIL full_done got %0d pulses want 1 at 1027", done_cyc_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_wrap();
    test_zero_len();
    test_ignored_start();
    test_reset_mid();
    test_full_depth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
